// File: rtl/boil_fsm.sv
// Boil kettle controller: receives sparged wort, runs a timed boil with two
// hop additions, chills to pitching temperature, pitches yeast and drains
// the kettle to the fermenter. Single Moore FSM with registered outputs.
module boil_fsm #(
  parameter logic [7:0] T_BOIL     = 8'd100,
  parameter logic [7:0] T_MAX      = 8'd110,
  parameter logic [7:0] T_PITCH    = 8'd20,
  parameter logic [7:0] L_MIN      = 8'd40,
  parameter logic [7:0] L_MAX      = 8'd200,
  parameter logic [7:0] TIMER_BOIL = 8'd60,
  parameter logic [7:0] HOP_2_AT   = 8'd45
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       wort_valid,
  input  logic       wort_done,
  input  logic [7:0] temp,
  input  logic [7:0] level,
  output logic       heat,
  output logic       cool,
  output logic       hop,
  output logic       yeast,
  output logic       drain,
  output logic       done,
  output logic       fault,
  output logic [3:0] state,
  output logic [7:0] boil_time
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    FILL  = 4'd1,
    RAMP  = 4'd2,
    BOIL  = 4'd3,
    COOL  = 4'd4,
    PITCH = 4'd5,
    DRAIN = 4'd6,
    DONE  = 4'd7,
    FAULT = 4'd8
  } state_t;

  state_t     r_state;
  logic [7:0] r_boil_time;
  logic       r_heat, r_cool, r_hop, r_yeast, r_drain, r_done, r_fault;
  logic [7:0] w_boil_next;

  // Saturating next value of the boil timer on a tick
  always_comb begin
    w_boil_next = r_boil_time;
    if (r_boil_time != 8'hFF) w_boil_next = r_boil_time + 8'd1;
  end

  // Main controller: state transitions and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_boil_time <= '0;
      r_heat      <= 1'b0;
      r_cool      <= 1'b0;
      r_hop       <= 1'b0;
      r_yeast     <= 1'b0;
      r_drain     <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      // hop, yeast and done are single-cycle pulses
      r_hop   <= 1'b0;
      r_yeast <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (wort_valid) r_state <= FILL;
        end
        FILL: begin
          if (level > L_MAX) begin
            r_state <= FAULT;
            r_heat  <= 1'b0;
            r_drain <= 1'b0;
            r_cool  <= 1'b1;
            r_fault <= 1'b1;
          end else if (wort_done && level >= L_MIN) begin
            r_state <= RAMP;
            r_heat  <= 1'b1;
          end else if (wort_done) begin
            r_state <= DRAIN;
            r_drain <= 1'b1;
          end
        end
        RAMP: begin
          if (temp > T_MAX) begin
            r_state <= FAULT;
            r_heat  <= 1'b0;
            r_cool  <= 1'b1;
            r_fault <= 1'b1;
          end else if (temp >= T_BOIL) begin
            r_state     <= BOIL;
            r_boil_time <= '0;
            r_hop       <= 1'b1;
          end
        end
        BOIL: begin
          if (temp > T_MAX) begin
            r_state <= FAULT;
            r_heat  <= 1'b0;
            r_cool  <= 1'b1;
            r_fault <= 1'b1;
          end else if (r_boil_time == TIMER_BOIL) begin
            r_state <= COOL;
            r_heat  <= 1'b0;
            r_cool  <= 1'b1;
          end else if (tick) begin
            r_boil_time <= w_boil_next;
            // second addition fires only on the edge the timer reaches it
            if (w_boil_next == HOP_2_AT && w_boil_next != r_boil_time)
              r_hop <= 1'b1;
          end
        end
        COOL: begin
          if (temp <= T_PITCH) begin
            r_state <= PITCH;
            r_cool  <= 1'b0;
            r_yeast <= 1'b1;
          end
        end
        PITCH: begin
          r_state <= DRAIN;
          r_drain <= 1'b1;
        end
        DRAIN: begin
          if (level == '0) begin
            r_state <= DONE;
            r_drain <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        FAULT: begin
          r_heat  <= 1'b0;
          r_drain <= 1'b0;
          r_cool  <= 1'b1;
          r_fault <= 1'b1;
        end
        default: begin
          r_state <= FAULT;
          r_heat  <= 1'b0;
          r_drain <= 1'b0;
          r_cool  <= 1'b1;
          r_fault <= 1'b1;
        end
      endcase
    end
  end

  assign state     = r_state;
  assign boil_time = r_boil_time;
  assign heat      = r_heat;
  assign cool      = r_cool;
  assign hop       = r_hop;
  assign yeast     = r_yeast;
  assign drain     = r_drain;
  assign done      = r_done;
  assign fault     = r_fault;

endmodule

// File: tb/tb_boil_fsm.sv
// Directed testbench for boil_fsm: nominal batch, discard path, overheat,
// overflow, simultaneous events and asynchronous reset mid-boil.
module tb_boil_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick, wort_valid, wort_done;
  logic [7:0] temp, level;
  logic       heat, cool, hop, yeast, drain, done, fault;
  logic [3:0] state;
  logic [7:0] boil_time;

  int errors = 0;
  int checks = 0;
  int hops   = 0;

  boil_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .wort_valid (wort_valid),
    .wort_done  (wort_done),
    .temp       (temp),
    .level      (level),
    .heat       (heat),
    .cool       (cool),
    .hop        (hop),
    .yeast      (yeast),
    .drain      (drain),
    .done       (done),
    .fault      (fault),
    .state      (state),
    .boil_time  (boil_time)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; tick = 1'b0; wort_valid = 1'b0; wort_done = 1'b0;
    temp = 8'd20; level = 8'd0;
    step();
    reset = 1'b1;
  endtask

  // IDLE -> FILL -> RAMP -> BOIL with level 120
  task automatic to_boil(input string tag);
    wort_valid = 1'b1; step(); wort_valid = 1'b0;
    chk({tag, "_fill"}, state, 1);
    level = 8'd120; wort_done = 1'b1; temp = 8'd60; step(); wort_done = 1'b0;
    chk({tag, "_ramp"}, state, 2);
    chk({tag, "_heat"}, heat, 1);
    temp = 8'd100; step();
    chk({tag, "_boil"}, state, 3);
    chk({tag, "_bt0"}, boil_time, 0);
    chk({tag, "_hop1"}, hop, 1);
  endtask

  initial begin
    do_reset();
    reset = 1'b0; #1;
    chk("rst_state", state, 0);
    chk("rst_bt", boil_time, 0);
    chk("rst_outs", {heat, cool, hop, yeast, drain, done, fault}, 0);
    step(); reset = 1'b1;

    // ---- 1 + 5: nominal batch with simultaneous events ----
    wort_valid = 1'b1; step(); wort_valid = 1'b0;
    chk("nom_fill", state, 1);
    level = 8'd50; step();
    chk("nom_fill_hold", state, 1);
    level = 8'd120; wort_done = 1'b1; temp = 8'd60; step(); wort_done = 1'b0;
    chk("nom_ramp", state, 2);
    chk("nom_heat", heat, 1);
    wort_done = 1'b1; temp = 8'd99; step(); wort_done = 1'b0;
    chk("ramp_wdone_ignored", state, 2);
    chk("ramp_hop0", hop, 0);
    temp = 8'd100; step();
    chk("nom_boil", state, 3);
    chk("nom_bt0", boil_time, 0);
    chk("nom_hop1", hop, 1);
    hops = 1;
    temp = 8'd90; step();
    chk("hop1_width", hop, 0);
    for (int i = 1; i <= 60; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
      if (hop) hops++;
      chk($sformatf("bt_%0d", i), boil_time, i);
      chk($sformatf("hop_at_%0d", i), hop, (i == 45) ? 1 : 0);
      chk($sformatf("boil_state_%0d", i), state, 3);
    end
    chk("nom_hop_count", hops, 2);
    tick = 1'b1; step(); tick = 1'b0;
    chk("nom_cool", state, 4);
    chk("tick_ignored_bt", boil_time, 60);
    chk("cool_heat", heat, 0);
    chk("cool_cool", cool, 1);
    temp = 8'd21; step();
    chk("cool_hold", state, 4);
    temp = 8'd20; step();
    chk("nom_pitch", state, 5);
    chk("pitch_yeast", yeast, 1);
    chk("pitch_cool", cool, 0);
    step();
    chk("nom_drain", state, 6);
    chk("drain_yeast", yeast, 0);
    chk("drain_on", drain, 1);
    level = 8'd1; step();
    chk("drain_hold", state, 6);
    level = 8'd0; step();
    chk("nom_done", state, 7);
    chk("done_pulse", done, 1);
    chk("done_drain", drain, 0);
    step();
    chk("nom_idle", state, 0);
    chk("done_width", done, 0);
    chk("bt_hold", boil_time, 60);

    // ---- 2: short batch discarded ----
    wort_valid = 1'b1; step(); wort_valid = 1'b0;
    chk("short_fill", state, 1);
    level = 8'd30; wort_done = 1'b1; step(); wort_done = 1'b0;
    chk("short_drain", state, 6);
    chk("short_drain_on", drain, 1);
    chk("short_heat", heat, 0);
    chk("short_hop", hop, 0);
    level = 8'd0; step();
    chk("short_done", state, 7);
    chk("short_done_pulse", done, 1);
    chk("short_heat2", heat, 0);
    step();
    chk("short_idle", state, 0);

    // ---- 3: overheat in BOIL ----
    do_reset();
    to_boil("oh");
    for (int i = 0; i < 10; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
    end
    chk("oh_bt10", boil_time, 10);
    temp = 8'd110; step();
    chk("oh_110_ok", state, 3);
    temp = 8'd111; step();
    chk("oh_fault_state", state, 8);
    chk("oh_outs", {heat, cool, hop, yeast, drain, fault}, 6'b010001);
    temp = 8'd20; wort_valid = 1'b1; step(); step(); wort_valid = 1'b0;
    chk("oh_sticky_state", state, 8);
    chk("oh_sticky_fault", fault, 1);

    // ---- 4: overflow in FILL, async release ----
    do_reset();
    wort_valid = 1'b1; step(); wort_valid = 1'b0;
    level = 8'd200; step();
    chk("of_200_ok", state, 1);
    level = 8'd201; step();
    chk("of_fault", state, 8);
    chk("of_fault_flag", fault, 1);
    #2 reset = 1'b0; #1;
    chk("of_async_state", state, 0);
    chk("of_async_outs", {heat, cool, hop, yeast, drain, done, fault}, 0);
    step(); reset = 1'b1; level = 8'd0;

    // ---- 6: reset mid-BOIL, restart ----
    to_boil("rb");
    for (int i = 0; i < 30; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
    end
    chk("rb_bt30", boil_time, 30);
    #2 reset = 1'b0; #1;
    chk("rb_async_state", state, 0);
    chk("rb_async_bt", boil_time, 0);
    chk("rb_async_heat", heat, 0);
    step(); reset = 1'b1; level = 8'd0; temp = 8'd20;
    to_boil("rb2");
    tick = 1'b1; step(); tick = 1'b0;
    chk("rb2_bt1", boil_time, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/boil_fsm.md
Name: boil_fsm

Overview:
Downstream neighbour of the mash/sparge controller. It receives sparged wort into the boil kettle, brings it to a timed boil with two hop additions, chills it to pitching temperature, pitches yeast, then drains the kettle to the fermenter. It is a single Moore FSM plus a boil timer, driven by kettle temp/level sensors and a 1 Hz tick.

Parameters:
T_BOIL, 100, kettle temp that starts the boil timer
T_MAX, 110, overheat limit; exceeding it faults
T_PITCH, 20, max temp at which yeast may be pitched
L_MIN, 40, minimum wort level worth boiling
L_MAX, 200, overflow limit; exceeding it faults
TIMER_BOIL, 60, boil length in ticks
HOP_2_AT, 45, boil_time value that triggers the second hop addition

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  one-cycle 1 Hz timebase strobe
wort_valid  in  1  upstream is pumping wort to this kettle
wort_done  in  1  one-cycle pulse: upstream transfer finished
temp  in  8  kettle temperature, unsigned
level  in  8  kettle level, unsigned
heat  out  1  heater enable
cool  out  1  chiller valve
hop  out  1  hop chute, one-cycle pulse
yeast  out  1  yeast chute, one-cycle pulse
drain  out  1  transfer pump to fermenter
done  out  1  one-cycle pulse: batch complete
fault  out  1  sticky fault flag
state  out  4  current state encoding
boil_time  out  8  ticks elapsed in BOIL

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset = 0 resets).
- Registered outputs: every output is a flop. An output changes on the clock edge where its transition is taken, so it is visible 1 cycle after the condition is sampled.
- Reset values: state = IDLE, boil_time = 0, all 1-bit outputs = 0.
- Reset mid-operation clears everything immediately, including fault.
- State encoding: IDLE = 0, FILL = 1, RAMP = 2, BOIL = 3, COOL = 4, PITCH = 5, DRAIN = 6, DONE = 7, FAULT = 8.
- IDLE: wort_valid -> FILL.
- FILL:
  - level > L_MAX -> FAULT.
  - Otherwise, wort_done with level >= L_MIN -> RAMP, heat = 1.
  - Otherwise, wort_done with level < L_MIN -> DRAIN, drain = 1. The batch is discarded; no heat, no hops.
- RAMP:
  - temp > T_MAX -> FAULT.
  - Otherwise, temp >= T_BOIL -> BOIL, boil_time = 0, hop = 1 (first addition, 1 cycle).
- BOIL:
  - tick increments boil_time (8-bit, saturates at 255, never wraps).
  - Second hop addition: hop = 1 for exactly one cycle on the edge where boil_time becomes HOP_2_AT.
  - Leaving: boil_time == TIMER_BOIL -> COOL, heat = 0, cool = 1. A tick in that same cycle is ignored.
  - temp > T_MAX -> FAULT; this has priority over the timer.
  - Temp dropping below T_BOIL does not pause the timer.
- COOL: temp <= T_PITCH -> PITCH, cool = 0, yeast = 1.
- PITCH: unconditional after 1 cycle -> DRAIN, yeast = 0, drain = 1.
- DRAIN: level == 0 -> DONE, drain = 0, done = 1.
- DONE: unconditional after 1 cycle -> IDLE, done = 0. boil_time holds its last value until the next BOIL entry.
- FAULT:
  - Outputs: heat = 0, hop = 0, yeast = 0, drain = 0, cool = 1, fault = 1.
  - No exit except reset.
- Input priority: wort_valid is ignored outside IDLE, and wort_done is ignored outside FILL.
- Pulses: hop, yeast and done are each exactly 1 cycle wide.
- Counts per path:
  - Normal batch: exactly 2 hop pulses and 1 yeast pulse.
  - Discard path: 0 hop pulses and 0 yeast pulses.
- Width rules: all comparisons are unsigned 8-bit. With TIMER_BOIL <= 255, BOIL always terminates.

Test Plan:
1. Nominal batch: wort_valid, level ramps to 120, wort_done; temp 60->100; 60 ticks; temp 100->20; level 120->0 -> state sequence 0,1,2,3,4,5,6,7,0. hop pulses at BOIL entry and at boil_time = 45. COOL entered at boil_time = 60. yeast and done each pulse once.
2. Short batch: wort_done with level = 30 -> FILL->DRAIN directly; heat never 1; 0 hop pulses; done after level = 0.
3. Overheat: temp = 111 in BOIL at boil_time = 10 -> FAULT next edge, heat = 0, cool = 1, fault = 1. temp back to 20 and wort_valid cause no exit.
4. Overflow: level = 201 during FILL -> FAULT. Release with reset = 0 for 1 cycle -> state = 0, fault = 0, all outputs 0 asynchronously.
5. Simultaneous events: tick in the same cycle boil_time reaches 60 -> COOL, boil_time stays 60. wort_done asserted while in RAMP has no effect.
6. Reset mid-BOIL at boil_time = 30 -> outputs clear without a clock edge. A new batch restarts boil_time from 0.
